// File: rtl/day7_pkg.sv
// Shared definitions for the Day 7 manifold map loader.
//   MAP_HEIGHT / MAP_WIDTH / MAP_MIDDLE : default grid geometry
//   CH_*                                : ASCII codes recognised in puzzle text
//   err_code_t                          : abort reasons reported on err_code
//   load_state_t                        : loader FSM state encoding
package day7_pkg;

  localparam int MAP_HEIGHT = 141;
  localparam int MAP_WIDTH  = 141;
  localparam int MAP_MIDDLE = 70;

  localparam logic [7:0] CH_DOT   = 8'h2E;  // '.' empty cell
  localparam logic [7:0] CH_SPLIT = 8'h5E;  // '^' splitter
  localparam logic [7:0] CH_SRC   = 8'h53;  // 'S' beam source
  localparam logic [7:0] CH_LF    = 8'h0A;  // '\n' end of line
  localparam logic [7:0] CH_CR    = 8'h0D;  // '\r' ignored

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_CHAR   = 3'd1,
    ERR_LONG_LINE  = 3'd2,
    ERR_SHORT_LINE = 3'd3,
    ERR_DUP_SRC    = 3'd4,
    ERR_NO_SRC     = 3'd5
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FINISH = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } load_state_t;

endpackage

// File: rtl/day7_map_loader_if.sv
// Byte-stream handshake between the text front end and the map loader.
//   in_data  : ASCII byte
//   in_valid : byte present
//   in_ready : consumer accepts the byte when in_valid && in_ready
// master = byte source, slave = loader.
interface day7_map_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/day7_char_decode.sv
// Combinational classifier for one byte of puzzle text.
//   ch        : ASCII byte
//   is_cell   : '.', '^' or 'S' (occupies one grid column)
//   cell_bit  : map bit for the cell (1 only for '^')
//   is_src    : 'S'
//   is_eol    : '\n'
//   is_ignore : '\r'
//   is_bad    : anything else
module day7_char_decode
  import day7_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_cell,
  output logic       cell_bit,
  output logic       is_src,
  output logic       is_eol,
  output logic       is_ignore,
  output logic       is_bad
);

  always_comb begin
    is_src    = (ch == CH_SRC);
    cell_bit  = (ch == CH_SPLIT);
    is_cell   = (ch == CH_DOT) || (ch == CH_SPLIT) || (ch == CH_SRC);
    is_eol    = (ch == CH_LF);
    is_ignore = (ch == CH_CR);
    is_bad    = !((ch == CH_DOT) || (ch == CH_SPLIT) || (ch == CH_SRC) ||
                  (ch == CH_LF)  || (ch == CH_CR));
  end

endmodule

// File: rtl/day7_map_loader.sv
// Streaming loader for the Day 7 manifold grid. Parses ASCII text one byte
// per handshake and writes each completed row into the solver's map RAM.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle pulse, begins or restarts a load
//   byte_in    : byte stream (in_data / in_valid / in_ready), slave side
//   wr_en      : one-cycle map write strobe
//   wr_row     : row index of the write
//   wr_data    : row image, column c at bit WIDTH-1-c, '^' = 1
//   start_col  : column of 'S' (valid when done)
//   start_row  : row of 'S' (valid when done)
//   done       : sticky, all rows written and exactly one 'S' seen
//   error      : sticky, load aborted
//   err_code   : abort reason (see err_code_t)
module day7_map_loader
  import day7_pkg::*;
#(
  parameter int HEIGHT = MAP_HEIGHT,
  parameter int WIDTH  = MAP_WIDTH,
  parameter int ROW_W  = $clog2(HEIGHT),
  parameter int COL_W  = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  day7_map_loader_if.slave     byte_in,
  output logic                 wr_en,
  output logic [ROW_W-1:0]     wr_row,
  output logic [WIDTH-1:0]     wr_data,
  output logic [COL_W-1:0]     start_col,
  output logic [ROW_W-1:0]     start_row,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           err_code
);

  load_state_t state_q, state_d;
  err_code_t   err_q, err_d;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [WIDTH-1:0] row_buf_q;
  logic             src_seen_q;

  logic is_cell, cell_bit, is_src, is_eol, is_ignore, is_bad;
  logic col_full, last_row;
  logic do_cell, do_write;
  logic [WIDTH-1:0] cell_mask, row_buf_upd;

  day7_char_decode u_decode (
    .ch        (byte_in.in_data),
    .is_cell   (is_cell),
    .cell_bit  (cell_bit),
    .is_src    (is_src),
    .is_eol    (is_eol),
    .is_ignore (is_ignore),
    .is_bad    (is_bad)
  );

  assign col_full = (col_q == COL_W'(WIDTH));
  assign last_row = (row_q == ROW_W'(HEIGHT - 1));

  // Status is decoded from the state register so done/error stay sticky
  // exactly as long as the FSM sits in DONE/ERROR.
  assign byte_in.in_ready = (state_q == ST_LOAD);
  assign done             = (state_q == ST_DONE);
  assign error            = (state_q == ST_ERROR);
  assign err_code         = err_q;

  // One-hot column select: text column c lands on bit WIDTH-1-c.
  always_comb begin
    cell_mask = '0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      cell_mask[WIDTH-1-c] = (col_q == COL_W'(c));
    end
    row_buf_upd = cell_bit ? (row_buf_q | cell_mask) : (row_buf_q & ~cell_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, abort code and datapath strobes. Bytes are only acted on in
  // LOAD; start overrides any byte presented on the same cycle.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    do_cell  = 1'b0;
    do_write = 1'b0;
    if (start) begin
      state_d = ST_LOAD;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (byte_in.in_valid) begin
            if (is_cell) begin
              if (col_full) begin
                state_d = ST_ERROR;
                err_d   = ERR_LONG_LINE;
              end else if (is_src && src_seen_q) begin
                state_d = ST_ERROR;
                err_d   = ERR_DUP_SRC;
              end else begin
                do_cell = 1'b1;
              end
            end else if (is_eol) begin
              if (col_full) begin
                do_write = 1'b1;
                if (last_row) state_d = ST_FINISH;
              end else if (col_q != '0) begin
                state_d = ST_ERROR;
                err_d   = ERR_SHORT_LINE;
              end
            end else if (is_bad) begin
              state_d = ST_ERROR;
              err_d   = ERR_BAD_CHAR;
            end else if (is_ignore) begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_FINISH: begin
          if (src_seen_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_NO_SRC;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= ERR_NONE;
      col_q      <= '0;
      row_q      <= '0;
      row_buf_q  <= '0;
      src_seen_q <= 1'b0;
      start_col  <= '0;
      start_row  <= '0;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_data    <= '0;
    end else begin
      err_q <= err_d;
      wr_en <= 1'b0;
      if (start) begin
        col_q      <= '0;
        row_q      <= '0;
        row_buf_q  <= '0;
        src_seen_q <= 1'b0;
        start_col  <= '0;
        start_row  <= '0;
      end else begin
        if (do_cell) begin
          row_buf_q <= row_buf_upd;
          col_q     <= col_q + COL_W'(1);
          if (is_src) begin
            src_seen_q <= 1'b1;
            start_col  <= col_q;
            start_row  <= row_q;
          end
        end
        // The write is registered on the '\n' handshake itself, so a later
        // abort can never retract it and a faulty row never reaches here.
        if (do_write) begin
          wr_en     <= 1'b1;
          wr_row    <= row_q;
          wr_data   <= row_buf_q;
          col_q     <= '0;
          row_buf_q <= '0;
          if (!last_row) row_q <= row_q + ROW_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_day7_map_loader.sv
module tb_day7_map_loader;

  localparam int SW = 5;
  localparam int SH = 3;
  localparam int BW = 141;
  localparam int BH = 141;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_start = 1'b0;
  logic b_start = 1'b0;

  always #5 clk = ~clk;

  day7_map_loader_if s_if ();
  day7_map_loader_if b_if ();

  logic          s_wr_en, s_done, s_error;
  logic [1:0]    s_wr_row, s_start_row;
  logic [SW-1:0] s_wr_data;
  logic [2:0]    s_start_col, s_err_code;

  logic          b_wr_en, b_done, b_error;
  logic [7:0]    b_wr_row, b_start_row, b_start_col;
  logic [BW-1:0] b_wr_data;
  logic [2:0]    b_err_code;

  day7_map_loader #(.HEIGHT(SH), .WIDTH(SW)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .byte_in(s_if),
    .wr_en(s_wr_en), .wr_row(s_wr_row), .wr_data(s_wr_data),
    .start_col(s_start_col), .start_row(s_start_row),
    .done(s_done), .error(s_error), .err_code(s_err_code)
  );

  day7_map_loader #(.HEIGHT(BH), .WIDTH(BW)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .byte_in(b_if),
    .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data),
    .start_col(b_start_col), .start_row(b_start_row),
    .done(b_done), .error(b_error), .err_code(b_err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned  row;
    logic [159:0] data;
  } wr_t;

  wr_t s_q[$];
  wr_t b_q[$];
  wr_t s_e, b_e;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (s_wr_en === 1'b1) begin
      if (s_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL s_unexpected_wr: row %0d data %0h with no write expected", s_wr_row, s_wr_data);
      end else begin
        s_e = s_q.pop_front();
        chk("s_wr_row", 160'(s_wr_row), s_e.data == s_e.data ? 160'(s_e.row) : '0);
        chk("s_wr_data", 160'(s_wr_data), s_e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b_wr_en === 1'b1) begin
      if (b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_wr: row %0d with no write expected", b_wr_row);
      end else begin
        b_e = b_q.pop_front();
        chk("b_wr_row", 160'(b_wr_row), 160'(b_e.row));
        chk("b_wr_data", 160'(b_wr_data), b_e.data);
      end
    end
  end

  task automatic s_exp(input int unsigned row, input logic [SW-1:0] d);
    s_q.push_back('{row: row, data: 160'(d)});
  endtask

  task automatic s_pulse_start();
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("s_error_cleared", 160'(s_error), 160'(0));
    chk("s_errcode_cleared", 160'(s_err_code), 160'(0));
  endtask

  task automatic s_send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      s_if.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    s_if.in_data  = b;
    s_if.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_if.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (s_if.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL s_send_timeout: in_ready %b, required 1 for byte %0h", s_if.in_ready, b);
    end
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
  endtask

  task automatic s_send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      s_send(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic s_expect_done(input int unsigned col, input int unsigned row);
    @(negedge clk);
    chk("s_done_early", 160'(s_done), 160'(0));
    chk("s_ready_finish", 160'(s_if.in_ready), 160'(0));
    @(negedge clk);
    chk("s_done", 160'(s_done), 160'(1));
    chk("s_error_on_done", 160'(s_error), 160'(0));
    chk("s_ready_done", 160'(s_if.in_ready), 160'(0));
    chk("s_start_col", 160'(s_start_col), 160'(col));
    chk("s_start_row", 160'(s_start_row), 160'(row));
    chk("s_pending_wr", 160'(s_q.size()), 160'(0));
    @(posedge clk); #1;
  endtask

  task automatic s_expect_err(input logic [2:0] code);
    @(negedge clk);
    chk("s_error", 160'(s_error), 160'(1));
    chk("s_err_code", 160'(s_err_code), 160'(code));
    chk("s_ready_err", 160'(s_if.in_ready), 160'(0));
    chk("s_done_err", 160'(s_done), 160'(0));
    repeat (3) @(negedge clk);
    chk("s_pending_wr", 160'(s_q.size()), 160'(0));
    chk("s_error_sticky", 160'(s_error), 160'(1));
    @(posedge clk); #1;
  endtask

  task automatic b_send(input logic [7:0] b);
    int n;
    b_if.in_data  = b;
    b_if.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (b_if.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (b_if.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL b_send_timeout: in_ready %b, required 1 for byte %0h", b_if.in_ready, b);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "big load stalled");
    end
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
  endtask

  initial begin
    logic [159:0] e;
    logic [7:0]   ch;
    s_if.in_data = '0; s_if.in_valid = 1'b0;
    b_if.in_data = '0; b_if.in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 160'(s_if.in_ready), 160'(0));
    chk("rst_wr_en", 160'(s_wr_en), 160'(0));
    chk("rst_done", 160'(s_done), 160'(0));
    chk("rst_error", 160'(s_error), 160'(0));
    chk("rst_err_code", 160'(s_err_code), 160'(0));
    chk("rst_wr_data", 160'(s_wr_data), 160'(0));
    chk("rst_b_ready", 160'(b_if.in_ready), 160'(0));
    @(posedge clk); #1;

    // Clean load, continuous valid
    s_pulse_start();
    s_exp(0, 5'b00000); s_exp(1, 5'b01000); s_exp(2, 5'b10001);
    s_send_str("..S..\n.^...\n^...^\n", 0);
    s_expect_done(2, 0);

    // CRLF, valid gaps, blank line between rows 1 and 2
    s_pulse_start();
    s_exp(0, 5'b00000); s_exp(1, 5'b01000); s_exp(2, 5'b10001);
    s_send_str("..S..\r\n.^...\r\n\r\n^...^\r\n", 2);
    s_expect_done(2, 0);

    // Bad character in row 1
    s_pulse_start();
    s_exp(0, 5'b00000);
    s_send_str("..S..\n.^.x", 0);
    s_expect_err(3'd1);

    // Long line, then short line
    s_pulse_start();
    s_send_str("..S...", 0);
    s_expect_err(3'd2);
    s_pulse_start();
    s_send_str("..S\n", 0);
    s_expect_err(3'd3);

    // Duplicate S
    s_pulse_start();
    s_exp(0, 5'b00000); s_exp(1, 5'b01000);
    s_send_str("..S..\n.^...\n^.S", 0);
    s_expect_err(3'd4);

    // Missing S: error one cycle after the final write
    s_pulse_start();
    s_exp(0, 5'b00000); s_exp(1, 5'b01000); s_exp(2, 5'b10001);
    s_send_str(".....\n.^...\n^...^\n", 0);
    @(negedge clk);
    chk("s_nos_error_early", 160'(s_error), 160'(0));
    @(negedge clk);
    chk("s_nos_error", 160'(s_error), 160'(1));
    chk("s_nos_code", 160'(s_err_code), 160'(5));
    chk("s_nos_done", 160'(s_done), 160'(0));
    chk("s_pending_wr", 160'(s_q.size()), 160'(0));
    @(posedge clk); #1;

    // Reset mid-row 1, then a clean reload from row 0
    s_pulse_start();
    s_exp(0, 5'b00000);
    s_send_str("..S..\n.^", 0);
    rst = 1'b1;
    @(negedge clk);
    chk("s_midrst_ready", 160'(s_if.in_ready), 160'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s_midrst_error", 160'(s_error), 160'(0));
    chk("s_midrst_done", 160'(s_done), 160'(0));
    chk("s_midrst_wr_row", 160'(s_wr_row), 160'(0));
    chk("s_pending_wr", 160'(s_q.size()), 160'(0));
    @(posedge clk); #1;
    s_pulse_start();
    s_exp(0, 5'b00100); s_exp(1, 5'b01000); s_exp(2, 5'b10001);
    s_send_str("..^S.\n.^...\n^...^\n", 0);
    s_expect_done(3, 0);

    // Full-size 141x141 image: '^' on the diagonal, S at row 0 column 70
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int r = 0; r < BH; r++) begin
      e = '0;
      e[BW-1-r] = 1'b1;
      b_q.push_back('{row: r, data: e});
      for (int c = 0; c < BW; c++) begin
        if (c == r)                  ch = 8'h5E;
        else if (r == 0 && c == 70)  ch = 8'h53;
        else                         ch = 8'h2E;
        b_send(ch);
      end
      b_send(8'h0A);
    end
    @(negedge clk);
    chk("b_done_early", 160'(b_done), 160'(0));
    @(negedge clk);
    chk("b_done", 160'(b_done), 160'(1));
    chk("b_error", 160'(b_error), 160'(0));
    chk("b_start_col", 160'(b_start_col), 160'(70));
    chk("b_start_row", 160'(b_start_row), 160'(0));
    chk("b_pending_wr", 160'(b_q.size()), 160'(0));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/day7_map_loader.md
Name: day7_map_loader

Overview:
- Streaming writer for the Day 7 manifold grid. It parses ASCII puzzle text arriving one byte per handshake and writes each completed row into the map memory that the timeline-counting solver reads.
- Row images are bit-identical to a binary memory image of the same text.
- It also reports the location of the beam source 'S'.
- It sits between the byte-stream front end (UART/host FIFO) and the solver's map RAM write port.

Parameters:
- HEIGHT, 141, number of grid rows to load
- WIDTH, 141, characters per row = bits per map word
- ROW_W, $clog2(HEIGHT), width of the row index
- COL_W, $clog2(WIDTH+1), width of the column counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins (or restarts) a load
- in_data  in  8  ASCII byte
- in_valid  in  1  byte present
- in_ready  out  1  loader accepts a byte when in_valid && in_ready
- wr_en  out  1  one-cycle map write strobe
- wr_row  out  ROW_W  map row index for the write
- wr_data  out  WIDTH  row image
- start_col  out  COL_W  text column of 'S' (0 = first character)
- start_row  out  ROW_W  row of 'S'
- done  out  1  sticky; all HEIGHT rows written and exactly one 'S' seen
- error  out  1  sticky; load aborted
- err_code  out  3  0 none, 1 bad char, 2 long line, 3 short line, 4 duplicate S, 5 missing S

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including in_ready, wr_en, done, error and err_code.
  - Row buffer, counters and S-found flag are cleared.
- States: IDLE, LOAD, FINISH, DONE, ERROR.
- start in any state:
  - Clears counters, row buffer, S flag, done, error and err_code.
  - Next state is LOAD.
  - start wins over a simultaneous byte, which is not accepted.
- in_ready:
  - Equals 1 only in LOAD.
  - Byte acceptance never stalls; there is no backpressure inside LOAD.
- Column mapping: column c (0-based position in the line) drives row-buffer bit WIDTH-1-c.
- Accepted byte in LOAD:
  - '.' (0x2E): bit = 0; col++.
  - '^' (0x5E): bit = 1; col++.
  - 'S' (0x53): bit = 0.
    - If no S seen yet: latch start_col = col and start_row = row.
    - Otherwise go to ERROR with code 4.
    - col++.
  - '\r' (0x0D): ignored.
  - '\n' (0x0A):
    - col == WIDTH: next cycle wr_en = 1, wr_row = row, wr_data = buffer. Then row++, col = 0 and the buffer is cleared.
    - col == 0: blank line, ignored.
    - Otherwise: ERROR, code 3.
  - '.', '^' or 'S' arriving while col == WIDTH: ERROR, code 2.
  - Any other byte: ERROR, code 1.
- Write timing:
  - wr_en is a single-cycle pulse, registered one cycle after the '\n' handshake.
  - wr_row and wr_data hold until the next write.
  - The first byte of the next row may be accepted on the cycle wr_en is high.
- Completion:
  - When the write of row HEIGHT-1 is issued, state goes to FINISH and in_ready drops that same cycle.
  - FINISH, one cycle later, checks the S flag. Set: DONE, with done = 1 from that edge. Clear: ERROR, code 5.
  - In total, done rises exactly 2 cycles after the final '\n' handshake.
- DONE and ERROR are sticky until start or rst.
  - in_ready = 0 in both.
  - No further writes occur.
  - Bytes are left unconsumed.
- Entering ERROR:
  - error = 1 and err_code are set on the same edge as the offending handshake.
  - Any pending row write is dropped; wr_en never pulses for a faulty row.
- start_col and start_row:
  - Valid only when done = 1.
  - Hold their values until the next start.
- Row counter never wraps; HEIGHT rows is a hard stop.
- rst mid-load: immediate return to IDLE with all outputs cleared; partially written map contents are undefined.

Decomposition:
- Shared package day7_pkg holds:
  - HEIGHT, WIDTH and MIDDLE defaults.
  - ASCII constants CH_DOT, CH_SPLIT, CH_SRC, CH_LF, CH_CR.
  - The err_code enumeration.
  - The loader state encoding.
- Natural sub-module: day7_char_decode. It is a combinational byte classifier giving is_cell, cell_bit, is_src, is_eol, is_ignore and is_bad. The FSM, counters and row buffer stay in day7_map_loader.

Test Plan (WIDTH=5, HEIGHT=3 unless noted):
- start, then stream "..S..\n.^...\n^...^\n" with continuous valid:
  - wr_en pulses 3 times with rows 0/1/2 and data 00000 / 01000 / 10001.
  - start_col = 2, start_row = 0.
  - done = 1 two cycles after the last '\n'.
- Same text with "\r\n" line endings, random in_valid gaps and one blank line between rows 1 and 2 -> identical writes and done.
- Row 1 sent as ".^.x.\n" -> error = 1, err_code = 1 at the 'x' handshake; no wr_en for row 1; in_ready = 0.
- Row 0 sent as "..S...\n" -> err_code 2 on the sixth cell. A fresh row 0 sent as "..S\n" -> err_code 3.
- Text with an 'S' in rows 0 and 2 -> err_code 4; text with no 'S' -> err_code 5 one cycle after the row 2 write; done stays 0.
- rst asserted mid-row 1; later start and a full valid stream -> clean load, with writes starting again at row 0. Also at default parameters (141x141), an image with S at column 70 -> 141 writes, start_col = 70, done = 1.
